// File: rtl/ddr_wr_sched_if.sv
// Write-port bundle between ddr_wr_sched (master) and axi_ctrl (slave).
// Latency: none, plain wires.
// Backpressure: wr_busy from the controller holds off new requests; wr_done closes each burst.
// Ports: wr_req (1-cycle pulse), wr_addr, wr_data (stable until wr_done), awlen,
//        wr_done (1-cycle completion pulse), wr_busy (controller busy level).
interface ddr_wr_sched_if #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 256
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        awlen;
    logic              wr_done;
    logic              wr_busy;

    modport master (output wr_req, wr_addr, wr_data, awlen, input wr_done, wr_busy);
    modport slave  (input wr_req, wr_addr, wr_data, awlen, output wr_done, wr_busy);
endinterface

// File: rtl/ddr_wr_sched.sv
// Round-robin DDR write scheduler: CH sources share the single axi_ctrl write port, each
// channel writing into its own wrapping frame-buffer region.
// Latency: grant edge -> wr_req/ch_ack next cycle; wr_done edge -> ch_done next cycle.
// Backpressure: no grant while init_done=0 or wr_busy=1; one burst in flight at a time.
// Ports: ch_req/ch_data/ch_frame_start in, ch_ack/ch_done out (per channel); pat_en/pat_data
//        override the write data; cur_ch shows the channel in flight; wr = axi_ctrl write port.
module ddr_wr_sched #(
    parameter int                CH           = 2,
    parameter int                ADDR_W       = 28,
    parameter int                DATA_W       = 256,
    parameter int                BURST_BYTES  = 32,
    parameter logic [ADDR_W-1:0] REGION_BYTES = 28'h080_0000,
    parameter logic [3:0]        AWLEN        = 4'd0,
    localparam int               CH_W         = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                 ddr_clk_100M,
    input  logic                 rstn,
    input  logic                 init_done,
    input  logic [CH-1:0]        ch_req,
    input  logic [CH*DATA_W-1:0] ch_data,
    input  logic [CH-1:0]        ch_frame_start,
    input  logic                 pat_en,
    input  logic [DATA_W-1:0]    pat_data,
    output logic [CH-1:0]        ch_ack,
    output logic [CH-1:0]        ch_done,
    output logic [CH_W-1:0]      cur_ch,
    ddr_wr_sched_if.master       wr
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr [CH];
    logic [CH-1:0]     pending;
    logic [CH_W-1:0]   last_grant;

    logic              grant_vld;
    logic [CH_W-1:0]   grant_idx;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_dat;
    logic              granting;
    logic              completing;
    logic [CH-1:0]     in_flight;
    int                best_dist;

    assign wr.awlen = AWLEN;

    function automatic logic [ADDR_W-1:0] base_of(input int c);
        return ADDR_W'(c) * REGION_BYTES;
    endfunction

    function automatic logic [ADDR_W-1:0] ptr_next(input int c, input logic [ADDR_W-1:0] p);
        logic [ADDR_W-1:0] nxt;
        nxt = p + ADDR_W'(BURST_BYTES);
        if (nxt >= base_of(c) + REGION_BYTES) begin
            return base_of(c);
        end
        return nxt;
    endfunction

    // Distance of channel c from the round-robin start point (last_grant+1); 0 = highest priority.
    function automatic int rr_dist(input int c, input logic [CH_W-1:0] lg);
        int d;
        d = c - int'(lg) - 1;
        if (d < 0) begin
            d = d + CH;
        end
        return d;
    endfunction

    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        best_dist = CH;
        for (int c = 0; c < CH; c++) begin
            if (ch_req[c] && (rr_dist(c, last_grant) < best_dist)) begin
                best_dist = rr_dist(c, last_grant);
                grant_vld = 1'b1;
                grant_idx = CH_W'(c);
            end
        end
    end

    always_comb begin
        grant_addr = '0;
        grant_dat  = '0;
        for (int c = 0; c < CH; c++) begin
            if (grant_idx == CH_W'(c)) begin
                grant_addr = ptr[c];
                grant_dat  = ch_data[c*DATA_W +: DATA_W];
            end
        end
        if (pat_en) begin
            grant_dat = pat_data;
        end
    end

    assign granting   = (state == IDLE) && init_done && !wr.wr_busy && grant_vld;
    assign completing = (state == WAIT_DONE) && wr.wr_done;

    // A channel being granted this edge already counts as in flight, so a frame_start that
    // coincides with its grant is deferred to completion rather than racing the address capture.
    always_comb begin
        in_flight = '0;
        for (int c = 0; c < CH; c++) begin
            in_flight[c] = ((state != IDLE) && (cur_ch == CH_W'(c))) ||
                           (granting && (grant_idx == CH_W'(c)));
        end
    end

    always_ff @(posedge ddr_clk_100M) begin
        if (!rstn) begin
            state      <= IDLE;
            wr.wr_req  <= 1'b0;
            wr.wr_addr <= '0;
            wr.wr_data <= '0;
            cur_ch     <= '0;
            ch_ack     <= '0;
            ch_done    <= '0;
            last_grant <= CH_W'(CH - 1);
            pending    <= '0;
            for (int c = 0; c < CH; c++) begin
                ptr[c] <= base_of(c);
            end
        end else begin
            wr.wr_req <= 1'b0;
            ch_ack    <= '0;
            ch_done   <= '0;

            case (state)
                IDLE: begin
                    if (granting) begin
                        wr.wr_req  <= 1'b1;
                        wr.wr_addr <= grant_addr;
                        wr.wr_data <= grant_dat;
                        cur_ch     <= grant_idx;
                        last_grant <= grant_idx;
                        ch_ack     <= CH'(1) << grant_idx;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (wr.wr_done) begin
                        ch_done <= CH'(1) << cur_ch;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            for (int c = 0; c < CH; c++) begin
                if (in_flight[c] && completing) begin
                    // A rewind requested during the burst replaces the normal increment.
                    ptr[c]     <= (pending[c] || ch_frame_start[c]) ? base_of(c) : ptr_next(c, ptr[c]);
                    pending[c] <= 1'b0;
                end else if (in_flight[c]) begin
                    pending[c] <= pending[c] | ch_frame_start[c];
                end else if (ch_frame_start[c] || pending[c]) begin
                    ptr[c]     <= base_of(c);
                    pending[c] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/ddr_wr_sched.md
# ddr_wr_sched

Parametrised DDR write scheduler that sits between up to CH write sources (HDMI-in capture, test-pattern generator, future processing stages) and the single write port of axi_ctrl. It arbitrates round-robin, generates per-channel wrapping frame-buffer addresses, and runs the wr_req/wr_done handshake. It replaces the fixed single-pattern write loop in top with a reusable multi-channel block.

## Interface
Parameters:
- CH, 2, number of write channels (1..8)
- ADDR_W, 28, DDR byte-address width (CTRL_ADDR_WIDTH)
- DATA_W, 256, burst data width (MEM_DQ_WIDTH*8)
- BURST_BYTES, 32, address increment per accepted write
- REGION_BYTES, 28'h080_0000, bytes per channel region; channel c base = c*REGION_BYTES; multiple of BURST_BYTES
- AWLEN, 4'd0, constant burst length driven on awlen

Ports:
- ddr_clk_100M  in  1  clock
- rstn  in  1  reset; synchronous, active-low
- init_done  in  1  DDR and ms72xx init complete; gates new grants
- ch_req  in  CH  per-channel write request, level, held until ch_ack
- ch_data  in  CH*DATA_W  per-channel write data; slice c = [c*DATA_W +: DATA_W]
- ch_frame_start  in  CH  one-cycle pulse; rewinds the channel pointer to its base
- pat_en  in  1  when 1, wr_data takes pat_data instead of ch_data
- pat_data  in  DATA_W  test-pattern data
- ch_ack  out  CH  one-cycle pulse: request granted, ch_data captured
- ch_done  out  CH  one-cycle pulse: granted write completed
- wr_req  out  1  to axi_ctrl, one-cycle pulse
- wr_addr  out  ADDR_W  to axi_ctrl
- wr_data  out  DATA_W  to axi_ctrl, stable from wr_req until wr_done
- awlen  out  4  to axi_ctrl, constant AWLEN
- wr_done  in  1  from axi_ctrl, one-cycle completion pulse
- wr_busy  in  1  from axi_ctrl
- cur_ch  out  $clog2(CH) (min 1)  channel in flight, for debug/led

## Operation
- FSM states: IDLE, ISSUE, WAIT_DONE.
- IDLE: grant when init_done=1, wr_busy=0, and any ch_req bit set. Winner is the first requester scanning from last_grant+1 (mod CH). On grant, register wr_addr=ptr[g], wr_data=(pat_en ? pat_data : ch_data[g]), cur_ch=g, last_grant=g; pulse wr_req and ch_ack[g]; go to ISSUE.
- ISSUE: lasts one cycle; wr_req returns to 0; go to WAIT_DONE.
- WAIT_DONE: hold wr_addr, wr_data, and cur_ch. On wr_done=1: pulse ch_done[g], update ptr[g], go to IDLE.
- Pointer update: next = ptr+BURST_BYTES. If next >= base+REGION_BYTES, ptr = base (wrap). Arithmetic is ADDR_W unsigned.
- ch_frame_start[c]: sets pending_rewind[c].
  - If c is not in flight, ptr[c]=base on the next cycle and pending clears.
  - If c is in flight, the rewind is applied at completion instead of the increment.
  - A frame_start coincident with completion also rewinds.
- init_done falling: no new grants; the burst in flight still completes.
- wr_done in IDLE or ISSUE is ignored.

## Timing
- Reset values: wr_req=0, ch_ack=0, ch_done=0, wr_addr=0, wr_data=0, cur_ch=0, awlen=AWLEN, ptr[c]=c*REGION_BYTES, last_grant=CH-1 (channel 0 wins first), pending=0, state=IDLE.
- Grant decision at edge T. wr_req, ch_ack, wr_addr, and wr_data are valid in cycle T+1. wr_req is low in T+2.
- wr_done seen at edge D. ch_done is high in D+1, the new ptr is visible in D+1, and state is IDLE in D+1.
- The earliest next grant is at edge D+1, so wr_req appears in D+2. Minimum spacing between wr_req pulses is 3 cycles plus the controller's latency.
- A channel must drop ch_req or present new data in the cycle after ch_ack. A ch_req still high at the next grant counts as a new request.
- Reset mid-burst: everything returns to reset values on the next edge and the outstanding wr_done is dropped.

## Test plan
- Single channel, pat_en=1, pat_data=X. The controller model returns wr_done 10 cycles after wr_req. Expect wr_addr 0, 32, 64, … and wr_data=X on each burst.
- Wrap: REGION_BYTES=128, 6 bursts on channel 0 -> wr_addr 0, 32, 64, 96, 0, 32.
- Round-robin: CH=3 with all ch_req held. Grants are 0, 1, 2, 0, 1, 2. Channel 1 addresses start at REGION_BYTES, channel 2 addresses at 2*REGION_BYTES.
- frame_start on channel 1 during its WAIT_DONE, pointer at base+64 -> next channel-1 wr_addr = base. frame_start on idle channel 0 -> next channel-0 address = 0.
- wr_busy held high for 20 cycles, or init_done=0 -> no wr_req. Release -> wr_req exactly 1 cycle after the grant edge.
- rstn low during WAIT_DONE -> all outputs at reset values. The stray wr_done after reset -> no ch_done.
